// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_incrementer.sv
// 32-bit sequential PC increment; wraps modulo 2^32.
module pc_incrementer
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o
);

    assign pc_next_o = pc_i + PC_STEP;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: single-outstanding memory read, redirect and squash.
// Optional macro FETCH_ALIGN_CHECK_EN: reject misaligned redirects and pulse AlignFault.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        MemReqReady,
    input  logic        MemRespValid,
    input  logic [31:0] MemRespData,
    output logic        MemReqValid,
    output logic [31:0] MemReqAddr,
    output logic        InstrValid,
    output logic [31:0] Instruction,
    output logic [31:0] PCResult,
    output logic [31:0] PCPlus4,
    output logic        AlignFault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  issued_pc_q, issued_pc_d;
    logic [31:0]  redir_pc_q, redir_pc_d;
    logic         squash_q, squash_d;
    logic         redir_pend_q, redir_pend_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_result_q, pc_result_d;
    logic [31:0]  pc_plus4_q, pc_plus4_d;
    logic         align_fault_q, align_fault_d;

    logic [31:0]  fetch_pc_inc;
    logic [31:0]  issued_pc_inc;
    logic [31:0]  redir_tgt;
    logic         redir_take;

    pc_incrementer u_fetch_inc (
        .pc_i      (fetch_pc_q),
        .pc_next_o (fetch_pc_inc)
    );

    pc_incrementer u_issued_inc (
        .pc_i      (issued_pc_q),
        .pc_next_o (issued_pc_inc)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_take    = BranchTaken && (BranchTarget[1:0] == 2'b00);
    assign redir_tgt     = BranchTarget;
    assign align_fault_d = BranchTaken && (BranchTarget[1:0] != 2'b00);
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^BranchTarget[1:0];
    assign redir_take    = BranchTaken;
    assign redir_tgt     = {BranchTarget[31:2], 2'b00};
    assign align_fault_d = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        issued_pc_d   = issued_pc_q;
        redir_pc_d    = redir_pc_q;
        squash_d      = squash_q;
        redir_pend_d  = redir_pend_q;
        instr_valid_d = 1'b0;
        instr_d       = instr_q;
        pc_result_d   = pc_result_q;
        pc_plus4_d    = pc_plus4_q;

        unique case (state_q)
            IDLE: begin
                if (redir_take) fetch_pc_d = redir_tgt;
                if (!Stall) state_d = REQ;
            end
            REQ: begin
                if (MemReqReady) begin
                    issued_pc_d  = fetch_pc_q;
                    redir_pend_d = 1'b0;
                    state_d      = WAIT;
                    // A redirect arriving now overrides one still pending.
                    if (redir_take) begin
                        squash_d   = 1'b1;
                        fetch_pc_d = redir_tgt;
                    end else if (redir_pend_q) begin
                        squash_d   = 1'b1;
                        fetch_pc_d = redir_pc_q;
                    end else begin
                        fetch_pc_d = fetch_pc_inc;
                    end
                end else if (redir_take) begin
                    redir_pend_d = 1'b1;
                    redir_pc_d   = redir_tgt;
                end
            end
            WAIT: begin
                if (redir_take) begin
                    squash_d   = 1'b1;
                    fetch_pc_d = redir_tgt;
                end
                if (MemRespValid) begin
                    if (!squash_q && !redir_take) begin
                        instr_valid_d = 1'b1;
                        instr_d       = MemRespData;
                        pc_result_d   = issued_pc_q;
                        pc_plus4_d    = issued_pc_inc;
                    end
                    squash_d = 1'b0;
                    state_d  = Stall ? IDLE : REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            issued_pc_q   <= '0;
            redir_pc_q    <= '0;
            squash_q      <= 1'b0;
            redir_pend_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            pc_result_q   <= '0;
            pc_plus4_q    <= '0;
            align_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            issued_pc_q   <= issued_pc_d;
            redir_pc_q    <= redir_pc_d;
            squash_q      <= squash_d;
            redir_pend_q  <= redir_pend_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pc_result_q   <= pc_result_d;
            pc_plus4_q    <= pc_plus4_d;
            align_fault_q <= align_fault_d;
        end
    end

    assign MemReqValid = (state_q == REQ);
    assign MemReqAddr  = fetch_pc_q;
    assign InstrValid  = instr_valid_q;
    assign Instruction = instr_q;
    assign PCResult    = pc_result_q;
    assign PCPlus4     = pc_plus4_q;
    assign AlignFault  = align_fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a zero-wait echoing instruction memory.
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        MemReqReady;
    logic        MemRespValid;
    logic [31:0] MemRespData;
    logic        MemReqValid;
    logic [31:0] MemReqAddr;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic [31:0] PCResult;
    logic [31:0] PCPlus4;
    logic        AlignFault;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam logic [31:0] DATA_TAG = 32'hA5A5_0000;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .MemReqReady  (MemReqReady),
        .MemRespValid (MemRespValid),
        .MemRespData  (MemRespData),
        .MemReqValid  (MemReqValid),
        .MemReqAddr   (MemReqAddr),
        .InstrValid   (InstrValid),
        .Instruction  (Instruction),
        .PCResult     (PCResult),
        .PCPlus4      (PCPlus4),
        .AlignFault   (AlignFault)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: memory answers the request accepted on this edge in the next cycle.
    task automatic step();
        logic        acc;
        logic [31:0] addr;
        acc  = MemReqValid && MemReqReady;
        addr = MemReqAddr;
        @(posedge Clk);
        #1;
        BranchTaken  = 1'b0;
        MemRespValid = acc;
        MemRespData  = acc ? (addr ^ DATA_TAG) : 32'h0;
        @(negedge Clk);
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] pc, input logic [31:0] pc4);
        check({tag, ".valid"}, {31'b0, InstrValid}, 32'd1);
        check({tag, ".pc"},    PCResult,            pc);
        check({tag, ".pc4"},   PCPlus4,             pc4);
        check({tag, ".instr"}, Instruction,         pc ^ DATA_TAG);
    endtask

    task automatic expect_req(input string tag, input logic [31:0] addr);
        check({tag, ".reqv"}, {31'b0, MemReqValid}, 32'd1);
        check({tag, ".addr"}, MemReqAddr,           addr);
    endtask

    initial begin
        Reset        = 1'b1;
        Stall        = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = 32'h0;
        MemReqReady  = 1'b1;
        MemRespValid = 1'b0;
        MemRespData  = 32'h0;
        @(negedge Clk);
        step();
        step();
        check("rst.reqv",  {31'b0, MemReqValid}, 32'd0);
        check("rst.addr",  MemReqAddr,           32'h0);
        check("rst.ivld",  {31'b0, InstrValid},  32'd0);
        check("rst.pc4",   PCPlus4,              32'h0);
        check("rst.align", {31'b0, AlignFault},  32'd0);

        // Sequential fetch: IDLE, then REQ 0x0, 2 cycles per instruction.
        Reset = 1'b0;
        step();
        expect_req("seq0", 32'h0);
        step();
        check("seq0.wait", {31'b0, MemReqValid}, 32'd0);
        step();
        expect_instr("seq0", 32'h0, 32'h4);
        expect_req("seq1", 32'h4);
        step();
        check("seq1.gap", {31'b0, InstrValid}, 32'd0);
        step();
        expect_instr("seq1", 32'h4, 32'h8);
        expect_req("seq2", 32'h8);

        // Redirect while the request is back-pressured: address held, then squash.
        MemReqReady  = 1'b0;
        BranchTaken  = 1'b1;
        BranchTarget = 32'h100;
        step();
        expect_req("hold1", 32'h8);
        step();
        expect_req("hold2", 32'h8);
        step();
        expect_req("hold3", 32'h8);
        MemReqReady = 1'b1;
        step();
        check("hold.acc", {31'b0, MemReqValid}, 32'd0);
        step();
        check("pend.squash", {31'b0, InstrValid}, 32'd0);
        expect_req("pend.redir", 32'h100);
        step();
        step();
        expect_instr("t100", 32'h100, 32'h104);
        expect_req("t104", 32'h104);

        // Redirect in WAIT coinciding with the response: dropped.
        step();
        check("wait.respv", {31'b0, MemRespValid}, 32'd1);
        BranchTaken  = 1'b1;
        BranchTarget = 32'h200;
        step();
        check("wait.drop", {31'b0, InstrValid}, 32'd0);
        expect_req("wait.redir", 32'h200);
        step();
        step();
        expect_instr("t200", 32'h200, 32'h204);

        // Stall during WAIT: response still delivered, then hold in IDLE.
        step();
        Stall = 1'b1;
        step();
        expect_instr("stall", 32'h204, 32'h208);
        check("stall.idle", {31'b0, MemReqValid}, 32'd0);
        step();
        step();
        check("stall.hold", {31'b0, MemReqValid}, 32'd0);
        Stall = 1'b0;
        step();
        expect_req("stall.rel", 32'h208);

        // Redirect accepted same cycle, into the wrap-around address.
        BranchTaken  = 1'b1;
        BranchTarget = 32'hFFFF_FFFC;
        step();
        step();
        check("wrap.squash", {31'b0, InstrValid}, 32'd0);
        expect_req("wrap.req", 32'hFFFF_FFFC);
        step();
        step();
        expect_instr("wrap", 32'hFFFF_FFFC, 32'h0);
        expect_req("wrap.next", 32'h0);

        // Misaligned redirect.
        BranchTaken  = 1'b1;
        BranchTarget = 32'h102;
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        check("align.pulse", {31'b0, AlignFault}, 32'd1);
        step();
        expect_instr("align.seq", 32'h0, 32'h4);
        expect_req("align.next", 32'h4);
`else
        check("align.pulse", {31'b0, AlignFault}, 32'd0);
        step();
        check("align.squash", {31'b0, InstrValid}, 32'd0);
        expect_req("align.redir", 32'h100);
`endif
        check("align.clear", {31'b0, AlignFault}, 32'd0);

        // Reset while a request is outstanding.
        step();
        Reset = 1'b1;
        step();
        check("mrst.reqv",  {31'b0, MemReqValid}, 32'd0);
        check("mrst.addr",  MemReqAddr,           32'h0);
        check("mrst.instr", Instruction,          32'h0);
        check("mrst.pc",    PCResult,             32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer that owns the fetch PC and consumes the branch-target address produced by the branch-target adder. It issues one instruction-memory read at a time over a valid/ready request channel, accepts the returned word, and hands the instruction plus its PC and PC+4 to the decode stage. Taken-branch redirects may arrive at any time; any in-flight fetch from the stale path is squashed.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- PC_STEP, 4, sequential increment in bytes
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Stall  in  1  hazard hold; blocks issue of a new request
- BranchTaken  in  1  one-cycle redirect strobe
- BranchTarget  in  32  redirect address, from branch-target adder
- MemReqReady  in  1  instruction memory accepts request
- MemRespValid  in  1  instruction word valid
- MemRespData  in  32  instruction word
- MemReqValid  out  1  request valid
- MemReqAddr  out  32  request address
- InstrValid  out  1  one-cycle pulse, Instruction/PCResult/PCPlus4 valid
- Instruction  out  32  fetched word
- PCResult  out  32  address of Instruction
- PCPlus4  out  32  PCResult + PC_STEP
- AlignFault  out  1  misaligned-redirect pulse (macro only, else tied 0)

## Operation
- Registers: FetchPC, state, Squash, RedirPend, RedirPC.
- States: IDLE, REQ, WAIT. Reset -> IDLE.
- IDLE: MemReqValid=0. Stall=0 -> REQ; else stay.
- REQ: MemReqValid=1, MemReqAddr=FetchPC, both stable until MemReqReady=1. On accept -> WAIT; FetchPC <= redirect target if one pending/arriving, else FetchPC+PC_STEP.
- WAIT: on MemRespValid: if Squash=0, latch Instruction=MemRespData, PCResult=issued address, PCPlus4=issued+PC_STEP, pulse InstrValid next cycle; clear Squash; -> REQ if Stall=0, else IDLE.
- Redirect (BranchTaken=1):
  - IDLE: FetchPC <= BranchTarget; no squash.
  - REQ, not accepted this cycle: RedirPend=1, RedirPC=BranchTarget; on acceptance Squash=1, FetchPC <= RedirPC, RedirPend cleared.
  - REQ, accepted same cycle: Squash=1, FetchPC <= BranchTarget.
  - WAIT: Squash=1, FetchPC <= BranchTarget; coincident MemRespValid is dropped (no InstrValid).
  - Multiple redirects before use: latest wins.
- MemRespValid outside WAIT ignored.
- Arithmetic: 32-bit unsigned, wraps (32'hFFFF_FFFC + 4 = 0).
- Stall sampled only on IDLE exit and WAIT completion; outstanding request always completes.

## Timing
- Reset values: MemReqValid 0, MemReqAddr RESET_PC, InstrValid 0, Instruction 0, PCResult 0, PCPlus4 0, AlignFault 0, FetchPC RESET_PC, Squash 0, RedirPend 0.
- Reset asserted in any state: all of the above next edge; outstanding request abandoned.
- First request: cycle 2 after Reset falls (IDLE, then REQ).
- Zero-wait memory (ready in REQ, response next cycle): InstrValid one cycle after response; steady throughput 1 instruction per 2 cycles.
- One outstanding request maximum.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: BranchTarget[1:0] != 0 -> redirect ignored, AlignFault pulses 1 cycle after BranchTaken, no squash.
- Undefined: BranchTarget[1:0] forced to 2'b00; AlignFault tied 0.

## Structure
- Package fetch_pkg: state enum (IDLE, REQ, WAIT), PC_STEP, default RESET_PC.
- One sub-module: pc_incrementer (32-bit FetchPC + PC_STEP), reused for PCPlus4.

## Test plan
- Reset release, ready always 1, memory echoes address -> requests 0x0, 0x4, 0x8; InstrValid with PCResult 0x0/0x4/0x8, PCPlus4 0x4/0x8/0xC.
- MemReqReady=0 for 3 cycles while BranchTaken, target 0x100 -> MemReqAddr held at 0x8 until accept; response squashed; next request 0x100.
- BranchTaken target 0x200 in WAIT coincident with MemRespValid -> no InstrValid; next request 0x200.
- Stall=1 during WAIT -> response delivered, then IDLE, no new request until Stall=0.
- FetchPC 32'hFFFF_FFFC accepted -> next request 0x0; PCPlus4 reports 0x0.
- With FETCH_ALIGN_CHECK_EN, target 0x102 -> AlignFault pulse, fetch continues sequentially; without macro -> redirect to 0x100.
